// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: requester ID encodings and default sizing shared by the arbiter, its ID FIFO and users
package sram_arbiter_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int STARVE_DEF = 8;
  typedef enum logic {ID_INST = 1'b0, ID_DATA = 1'b1} req_id_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: SRAM-like req/addr_ok/data_ok bus; master drives req/wr/size/wstrb/addr/wdata, slave drives addr_ok/data_ok/rdata
interface sram_arbiter_if;
  logic req;
  logic wr;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [31:0] rdata;
  modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_arbiter_id_fifo.sv
// id_fifo: DEPTH-entry FIFO of requester IDs; in clk/reset/push/pop/din, out head/full/empty (push ignored when full, pop when empty)
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en & ~rd_en) count <= count + 1'b1;
      else if (rd_en & ~wr_en) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: data-priority 2:1 SRAM bus arbiter with inst starvation guard; in clk/reset, slave ports inst_sram/data_sram, master port mem, out err_spurious
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic clk,
  input  logic reset,
  sram_arbiter_if.slave  inst_sram,
  sram_arbiter_if.slave  data_sram,
  sram_arbiter_if.master mem,
  output logic err_spurious
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic force_inst, grant_data, grant_inst, full, empty, push, pop;
  logic [0:0] head, din;
  assign force_inst = starve_cnt == SW'(STARVE_LIMIT);
  assign grant_data = data_sram.req & ~force_inst;
  assign grant_inst = inst_sram.req & (~data_sram.req | force_inst);
  assign mem.req   = (grant_data | grant_inst) & ~full;
  assign mem.wr    = grant_inst ? inst_sram.wr    : data_sram.wr;
  assign mem.size  = grant_inst ? inst_sram.size  : data_sram.size;
  assign mem.wstrb = grant_inst ? inst_sram.wstrb : data_sram.wstrb;
  assign mem.addr  = grant_inst ? inst_sram.addr  : data_sram.addr;
  assign mem.wdata = grant_inst ? inst_sram.wdata : data_sram.wdata;
  assign inst_sram.addr_ok = mem.addr_ok & grant_inst & ~full;
  assign data_sram.addr_ok = mem.addr_ok & grant_data & ~full;
  assign push = mem.req & mem.addr_ok;
  assign pop  = mem.data_ok & ~empty;
  assign din  = grant_inst ? ID_INST : ID_DATA;
  assign inst_sram.data_ok = pop & (head == ID_INST);
  assign data_sram.data_ok = pop & (head == ID_DATA);
  assign inst_sram.rdata = mem.rdata;
  assign data_sram.rdata = mem.rdata;
  id_fifo #(.DEPTH(DEPTH), .WIDTH(1)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .head(head), .full(full), .empty(empty)
  );
  // starve_cnt saturates at STARVE_LIMIT because the increment term excludes force_inst
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (mem.data_ok & empty) err_spurious <= 1'b1;
      starve_cnt <= (inst_sram.addr_ok | ~inst_sram.req) ? '0 :
                    (data_sram.req & ~force_inst & ~full) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
endmodule
